// File: rtl/ysyx_22050019_rd_arbiter.sv
// Two-master AXI-style read arbiter: icache (m0) and dcache (m1) share one read port.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise m1 wins every tie.
module ysyx_22050019_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_ar_valid_i,
    output logic                  m0_ar_ready_o,
    input  logic [ADDR_WIDTH-1:0] m0_ar_addr_i,
    input  logic [LEN_WIDTH-1:0]  m0_ar_len_i,
    output logic                  m0_r_valid_o,
    input  logic                  m0_r_ready_i,
    output logic [1:0]            m0_r_resp_o,
    output logic [DATA_WIDTH-1:0] m0_r_data_o,

    input  logic                  m1_ar_valid_i,
    output logic                  m1_ar_ready_o,
    input  logic [ADDR_WIDTH-1:0] m1_ar_addr_i,
    input  logic [LEN_WIDTH-1:0]  m1_ar_len_i,
    output logic                  m1_r_valid_o,
    input  logic                  m1_r_ready_i,
    output logic [1:0]            m1_r_resp_o,
    output logic [DATA_WIDTH-1:0] m1_r_data_o,

    output logic                  s_ar_valid_o,
    input  logic                  s_ar_ready_i,
    output logic [ADDR_WIDTH-1:0] s_ar_addr_o,
    output logic [LEN_WIDTH-1:0]  s_ar_len_o,
    input  logic                  s_r_valid_i,
    output logic                  s_r_ready_o,
    input  logic [1:0]            s_r_resp_i,
    input  logic [DATA_WIDTH-1:0] s_r_data_i,

    output logic [1:0]            grant_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R
    } state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] cnt;

    logic pick_m1;
    logic in_idle;
    logic in_r;
    logic ar_hs;
    logic beat_hs;

`ifdef ARB_ROUND_ROBIN_EN
    // Set means m1 took the previous grant, so m0 wins the next tie.
    logic last_m1;

    assign pick_m1 = (m0_ar_valid_i & m1_ar_valid_i) ? ~last_m1
                                                     : m1_ar_valid_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_m1 <= 1'b1;
        end else if (ar_hs) begin
            last_m1 <= pick_m1;
        end
    end
`else
    assign pick_m1 = m1_ar_valid_i;
`endif

    assign in_idle = (state == S_IDLE) & ~rst;
    assign in_r    = (state == S_R);

    assign m0_ar_ready_o = in_idle & m0_ar_valid_i & ~pick_m1;
    assign m1_ar_ready_o = in_idle & pick_m1;
    assign ar_hs         = m0_ar_ready_o | m1_ar_ready_o;

    always_comb begin
        m0_r_valid_o = 1'b0;
        m0_r_resp_o  = 2'b00;
        m0_r_data_o  = '0;
        m1_r_valid_o = 1'b0;
        m1_r_resp_o  = 2'b00;
        m1_r_data_o  = '0;
        s_r_ready_o  = 1'b0;
        if (in_r) begin
            unique case (1'b1)
                grant_o[0]: begin
                    m0_r_valid_o = s_r_valid_i;
                    m0_r_resp_o  = s_r_resp_i;
                    m0_r_data_o  = s_r_data_i;
                    s_r_ready_o  = m0_r_ready_i;
                end
                grant_o[1]: begin
                    m1_r_valid_o = s_r_valid_i;
                    m1_r_resp_o  = s_r_resp_i;
                    m1_r_data_o  = s_r_data_i;
                    s_r_ready_o  = m1_r_ready_i;
                end
                default: s_r_ready_o = 1'b0;
            endcase
        end
    end

    assign beat_hs = s_r_valid_i & s_r_ready_o;
    assign busy_o  = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            grant_o      <= 2'b00;
            s_ar_valid_o <= 1'b0;
            s_ar_addr_o  <= '0;
            s_ar_len_o   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (ar_hs) begin
                        s_ar_addr_o  <= pick_m1 ? m1_ar_addr_i : m0_ar_addr_i;
                        s_ar_len_o   <= pick_m1 ? m1_ar_len_i : m0_ar_len_i;
                        cnt          <= pick_m1 ? m1_ar_len_i : m0_ar_len_i;
                        grant_o      <= pick_m1 ? 2'b10 : 2'b01;
                        s_ar_valid_o <= 1'b1;
                        state        <= S_AR;
                    end
                end
                S_AR: begin
                    if (s_ar_ready_i) begin
                        s_ar_valid_o <= 1'b0;
                        state        <= S_R;
                    end
                end
                S_R: begin
                    // No rlast: the loaded length alone ends the burst.
                    if (beat_hs) begin
                        if (cnt == '0) begin
                            grant_o <= 2'b00;
                            state   <= S_IDLE;
                        end else begin
                            cnt <= cnt - LEN_WIDTH'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
